// File: rtl/topk_drain_if.sv
// Snapshot-load and output-stream bundle for the top-k drain.
// The slave side is the drain itself; the master side is its environment.
interface topk_drain_if #(
  parameter int W  = 5,
  parameter int N  = 4,
  parameter int CW = 3
);
  logic               load;
  logic [N*W-1:0]     din;
  logic [CW-1:0]      cnt;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_data;
  logic [CW-1:0]      out_idx;
  logic               out_last;
  logic               done;
  logic               order_err;

  modport slave (
    input  load, din, cnt, out_ready,
    output busy, out_valid, out_data,
    output out_idx, out_last, done,
    output order_err
  );

  modport master (
    output load, din, cnt, out_ready,
    input  busy, out_valid, out_data,
    input  out_idx, out_last, done,
    input  order_err
  );
endinterface

// File: rtl/topk_drain.sv
// Captures a sorted top-k snapshot and streams valid slots largest first,
// flagging any snapshot that is not non-increasing within its count.
module topk_drain #(
  parameter int W  = 5,
  parameter int N  = 4,
  parameter int CW = 3
) (
  input logic         clk,
  input logic         rst,
  topk_drain_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic [N-1:0][W-1:0]   buf_q, buf_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [N-1:0][W-1:0]   snap;
  logic [CW-1:0]         cnt_c;
  logic                  ord_bad;
  logic                  last;
  logic                  hs;

  assign snap  = bus.din;
  assign cnt_c = (bus.cnt > CW'(N)) ? CW'(N) : bus.cnt;

  // Only adjacent pairs inside the clamped occupancy are checked.
  always_comb begin
    ord_bad = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      if (CW'(i + 1) < cnt_c &&
          $signed(snap[i]) < $signed(snap[i+1]))
        ord_bad = 1'b1;
    end
  end

  assign last = (state_q == SEND) &&
                (idx_q == cnt_q - CW'(1));
  assign hs   = (state_q == SEND) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          err_d = ord_bad;
          if (cnt_c == '0) begin
            done_d = 1'b1;
          end else begin
            buf_d   = snap;
            cnt_d   = cnt_c;
            idx_d   = '0;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (hs) begin
          if (last) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy      = (state_q == SEND);
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_data  = buf_q[idx_q[IW-1:0]];
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last;
  assign bus.done      = done_q;
  assign bus.order_err = err_q;
endmodule

// File: tb/tb_topk_drain.sv
// Directed self-checking bench for topk_drain.
// Each task drives one scenario and checks its outputs inline.
module tb_topk_drain;
  localparam int W  = 5;
  localparam int N  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  topk_drain_if #(.W(W), .N(N), .CW(CW)) bus ();

  topk_drain #(.W(W), .N(N), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] pack(
    input int s0, input int s1,
    input int s2, input int s3
  );
    logic [N*W-1:0] r;
    r[0*W +: W] = W'(s0);
    r[1*W +: W] = W'(s1);
    r[2*W +: W] = W'(s2);
    r[3*W +: W] = W'(s3);
    return r;
  endfunction

  task automatic test_reset();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.out_last !== 1'b0 || bus.done !== 1'b0 ||
        bus.order_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: busy=%b vld=%b last=%b done=%b err=%b required all 0",
               bus.busy, bus.out_valid, bus.out_last, bus.done, bus.order_err);
    end
    n_cmp++;
    if (bus.out_data !== '0 || bus.out_idx !== '0) begin
      n_err++;
      $display("FAIL reset_data: data=%h idx=%0d required 0/0",
               bus.out_data, bus.out_idx);
    end
  endtask

  task automatic test_drain();
    int exp[4] = '{7, 3, -2, -16};
    logic [W-1:0] ev;
    bus.din = pack(7, 3, -2, -16);
    bus.cnt = 3'd4;
    bus.out_ready = 1'b1;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL drain_busy: got %b required 1", bus.busy);
    end
    for (int k = 0; k < 4; k++) begin
      ev = W'(exp[k]);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== ev ||
          bus.out_idx !== CW'(k) || bus.out_last !== (k == 3)) begin
        n_err++;
        $display("FAIL drain_word%0d: vld=%b data=%0d idx=%0d last=%b required 1/%0d/%0d/%b",
                 k, bus.out_valid, $signed(bus.out_data), bus.out_idx,
                 bus.out_last, exp[k], k, (k == 3));
      end
      tick();
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 ||
        bus.out_valid !== 1'b0 || bus.order_err !== 1'b0) begin
      n_err++;
      $display("FAIL drain_end: done=%b busy=%b vld=%b err=%b required 1/0/0/0",
               bus.done, bus.busy, bus.out_valid, bus.order_err);
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL drain_done_pulse: got %b required 0", bus.done);
    end
  endtask

  task automatic test_stall();
    int exp[4] = '{7, 3, -2, -16};
    bit rdy[7] = '{1, 0, 0, 1, 0, 1, 1};
    logic [W-1:0] ev;
    int e = 0;
    int nhs = 0;
    bus.din = pack(7, 3, -2, -16);
    bus.cnt = 3'd4;
    bus.out_ready = 1'b0;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int c = 0; c < 7; c++) begin
      bus.out_ready = rdy[c];
      ev = W'(exp[e]);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== ev ||
          bus.out_idx !== CW'(e) || bus.out_last !== (e == 3)) begin
        n_err++;
        $display("FAIL stall_cyc%0d: vld=%b data=%0d idx=%0d last=%b required 1/%0d/%0d/%b",
                 c, bus.out_valid, $signed(bus.out_data), bus.out_idx,
                 bus.out_last, exp[e], e, (e == 3));
      end
      if (rdy[c]) begin
        nhs++;
        if (e < 3) e++;
      end
      tick();
    end
    bus.out_ready = 1'b1;
    n_cmp++;
    if (nhs != 4 || bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_end: hs=%0d done=%b vld=%b required 4/1/0",
               nhs, bus.done, bus.out_valid);
    end
    tick();
  endtask

  task automatic test_empty();
    bus.din = pack(1, 1, 1, 1);
    bus.cnt = 3'd0;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    n_cmp++;
    if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL empty_load: done=%b vld=%b busy=%b required 1/0/0",
               bus.done, bus.out_valid, bus.busy);
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL empty_after: done=%b vld=%b required 0/0",
               bus.done, bus.out_valid);
    end
  endtask

  task automatic test_order_err();
    int exp[4] = '{2, 5, 1, 0};
    logic [W-1:0] ev;
    bus.din = pack(2, 5, 1, 0);
    bus.cnt = 3'd4;
    bus.out_ready = 1'b1;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    n_cmp++;
    if (bus.order_err !== 1'b1) begin
      n_err++;
      $display("FAIL order_err_set: got %b required 1", bus.order_err);
    end
    for (int k = 0; k < 4; k++) begin
      ev = W'(exp[k]);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== ev ||
          bus.out_idx !== CW'(k)) begin
        n_err++;
        $display("FAIL order_word%0d: vld=%b data=%0d idx=%0d required 1/%0d/%0d",
                 k, bus.out_valid, $signed(bus.out_data), bus.out_idx,
                 exp[k], k);
      end
      tick();
    end
    n_cmp++;
    if (bus.order_err !== 1'b1 || bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL order_err_hold: err=%b done=%b required 1/1",
               bus.order_err, bus.done);
    end
    bus.din = pack(4, 4, -1, -16);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    n_cmp++;
    if (bus.order_err !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL order_err_clear: err=%b busy=%b required 0/1",
               bus.order_err, bus.busy);
    end
    for (int k = 0; k < 4; k++) tick();
    tick();
  endtask

  task automatic test_clamp_ignore();
    int exp[4] = '{15, 10, 5, 0};
    logic [W-1:0] ev;
    bus.din = pack(15, 10, 5, 0);
    bus.cnt = 3'd7;
    bus.out_ready = 1'b1;
    bus.load = 1'b1;
    tick();
    bus.din = pack(9, 9, 9, 9);
    bus.cnt = 3'd2;
    for (int k = 0; k < 4; k++) begin
      ev = W'(exp[k]);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== ev ||
          bus.out_idx !== CW'(k) || bus.out_last !== (k == 3)) begin
        n_err++;
        $display("FAIL clamp_word%0d: vld=%b data=%0d idx=%0d last=%b required 1/%0d/%0d/%b",
                 k, bus.out_valid, $signed(bus.out_data), bus.out_idx,
                 bus.out_last, exp[k], k, (k == 3));
      end
      tick();
    end
    bus.load = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL clamp_end: vld=%b busy=%b done=%b required 0/0/1",
               bus.out_valid, bus.busy, bus.done);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL clamp_ignored: vld=%b busy=%b done=%b required 0/0/0",
               bus.out_valid, bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_mid();
    int exp[4] = '{6, 2, 1, -3};
    logic [W-1:0] ev;
    bus.din = pack(7, 3, -2, -16);
    bus.cnt = 3'd4;
    bus.out_ready = 1'b1;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.out_idx !== 3'd2 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre: idx=%0d busy=%b required 2/1",
               bus.out_idx, bus.busy);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.out_data !== '0 || bus.out_idx !== '0 ||
        bus.out_last !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async: vld=%b busy=%b data=%h idx=%0d last=%b done=%b required all 0",
               bus.out_valid, bus.busy, bus.out_data, bus.out_idx,
               bus.out_last, bus.done);
    end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_no_done: got %b required 0", bus.done);
    end
    bus.din = pack(6, 2, 1, -3);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ev = W'(exp[k]);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== ev ||
          bus.out_idx !== CW'(k)) begin
        n_err++;
        $display("FAIL rst_word%0d: vld=%b data=%0d idx=%0d required 1/%0d/%0d",
                 k, bus.out_valid, $signed(bus.out_data), bus.out_idx,
                 exp[k], k);
      end
      tick();
    end
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL rst_redrain_done: got %b required 1", bus.done);
    end
  endtask

  initial begin
    bus.load = 1'b0;
    bus.din = '0;
    bus.cnt = '0;
    bus.out_ready = 1'b0;
    #2;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    test_reset();
    test_drain();
    test_stall();
    test_empty();
    test_order_err();
    test_clamp_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
